// File: rtl/datapath_pkg.sv
// Shared definitions for the sequential bus datapath: opcodes, FSM states
// and default sizing.
package datapath_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_NREGS = 16;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_SHL = 3'd4,
      OP_SHR = 3'd5,
      OP_MUL = 3'd6,
      OP_DIV = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOADY = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } state_t;
endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per
// cycle for WIDTH cycles. hi/lo present the result of the step in progress.
module seq_muldiv
   import datapath_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             go,
   input  logic             div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc, qm, opnd;
   logic             is_div;
   logic [WIDTH:0]   sum, trial;

   // acc: partial product high half / partial remainder; qm: multiplier / quotient
   always_comb begin
      sum   = {1'b0, acc} + (qm[0] ? {1'b0, opnd} : '0);
      trial = {acc, qm[WIDTH-1]};
      hi    = sum[WIDTH:1];
      lo    = {sum[0], qm[WIDTH-1:1]};
      if (is_div) begin
         if (trial >= {1'b0, opnd}) begin
            hi = trial[WIDTH-1:0] - opnd;
            lo = {qm[WIDTH-2:0], 1'b1};
         end else begin
            hi = trial[WIDTH-1:0];
            lo = {qm[WIDTH-2:0], 1'b0};
         end
      end
   end

   // ready marks the last step so the caller can latch hi/lo on that edge
   assign ready = (cnt == CW'(1));

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt    <= '0;
         acc    <= '0;
         qm     <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
      end else if (go) begin
         cnt    <= CW'(WIDTH);
         acc    <= '0;
         qm     <= a;
         opnd   <= b;
         is_div <= div;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
         acc <= hi;
         qm  <= lo;
      end
   end
endmodule

// File: rtl/bus_datapath_seq.sv
// Register file + Y/Z bus datapath driven by a four-state sequencer;
// MUL/DIV are delegated to the iterative seq_muldiv engine.
module bus_datapath_seq
   import datapath_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NREGS   = DEF_NREGS,
   parameter bit R0_ZERO = 1'b1,
   localparam int AW     = $clog2(NREGS),
   localparam int SW     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AW-1:0]    ra,
   input  logic [AW-1:0]    rb,
   input  logic [AW-1:0]    rc,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_data,
   input  logic [AW-1:0]    dbg_sel,
   output logic [WIDTH-1:0] dbg_data,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   state_t           state, state_nx;
   op_t              op_q;
   logic [AW-1:0]    ra_q, rb_q, rc_q;
   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] y, zhi, zlo, hi_r, lo_r;
   logic [WIDTH-1:0] b_val, c_val, alu_hi, alu_lo, md_hi, md_lo;
   logic             done_r, err_r, is_iter, div0, go, md_ready;

   assign b_val    = (R0_ZERO && rb_q == '0) ? '0 : regs[rb_q];
   assign c_val    = (R0_ZERO && rc_q == '0) ? '0 : regs[rc_q];
   assign dbg_data = (R0_ZERO && dbg_sel == '0) ? '0 : regs[dbg_sel];

   assign is_iter = (op_q == OP_MUL) || (op_q == OP_DIV);
   assign div0    = (op_q == OP_DIV) && (c_val == '0);
   // engine loads in LOADY from the same source Y receives, so EXEC spends exactly WIDTH cycles
   assign go      = (state == LOADY) && is_iter && !div0;

   seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk   (clk),
      .clr   (clr),
      .go    (go),
      .div   (op_q == OP_DIV),
      .a     (b_val),
      .b     (c_val),
      .ready (md_ready),
      .hi    (md_hi),
      .lo    (md_lo)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = LOADY;
         LOADY:   state_nx = EXEC;
         EXEC:    if (!is_iter || div0 || md_ready) state_nx = WRITE;
         WRITE:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      alu_hi = '0;
      alu_lo = '0;
      case (op_q)
         OP_ADD: alu_lo = y + c_val;
         OP_SUB: alu_lo = y - c_val;
         OP_AND: alu_lo = y & c_val;
         OP_OR:  alu_lo = y | c_val;
         OP_SHL: alu_lo = y << c_val[SW-1:0];
         OP_SHR: alu_lo = y >> c_val[SW-1:0];
         default: begin
            if (div0) begin
               alu_hi = y;
               alu_lo = '1;
            end else begin
               alu_hi = md_hi;
               alu_lo = md_lo;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         op_q   <= OP_ADD;
         ra_q   <= '0;
         rb_q   <= '0;
         rc_q   <= '0;
         y      <= '0;
         zhi    <= '0;
         zlo    <= '0;
         hi_r   <= '0;
         lo_r   <= '0;
         done_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         case (state)
            IDLE: begin
               // a simultaneous load is dropped in favour of start
               if (start) begin
                  op_q <= op_t'(op);
                  ra_q <= ra;
                  rb_q <= rb;
                  rc_q <= rc;
               end else if (load_en && !(R0_ZERO && ra == '0)) begin
                  regs[ra] <= load_data;
               end
            end
            LOADY: y <= b_val;
            EXEC: begin
               if (state_nx == WRITE) begin
                  zhi <= alu_hi;
                  zlo <= alu_lo;
               end
            end
            WRITE: begin
               if (!(R0_ZERO && ra_q == '0)) regs[ra_q] <= zlo;
               if (is_iter) begin
                  hi_r <= zhi;
                  lo_r <= zlo;
               end
               done_r <= 1'b1;
               err_r  <= div0;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = done_r;
   assign err  = err_r;
   assign hi   = hi_r;
   assign lo   = lo_r;
endmodule

// File: tb/tb_bus_datapath_seq.sv
// Scoreboarded random/directed bench for bus_datapath_seq (WIDTH=32, NREGS=16).
module tb_bus_datapath_seq;
   logic        clk = 1'b0;
   logic        clr;
   logic        start, load_en;
   logic [2:0]  op;
   logic [3:0]  ra, rb, rc, dbg_sel, stim_sel, mon_sel;
   logic        mon_own;
   logic [31:0] load_data, dbg_data, hi, lo;
   logic        busy, done, err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int          lat;
      int          scyc;
      logic [3:0]  dest;
      logic [31:0] dval;
      logic [31:0] ehi;
      logic [31:0] elo;
      logic        eerr;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mregs [16];
   logic [31:0] mhi, mlo;

   assign dbg_sel = mon_own ? mon_sel : stim_sel;

   bus_datapath_seq #(.WIDTH(32), .NREGS(16), .R0_ZERO(1'b1)) dut (
      .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
      .load_en(load_en), .load_data(load_data), .dbg_sel(dbg_sel),
      .dbg_data(dbg_data), .busy(busy), .done(done), .err(err), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // monitor: pops one expectation per done pulse
   initial begin
      exp_t e;
      mon_own = 1'b0;
      mon_sel = '0;
      forever begin
         @(negedge clk);
         if (clr === 1'b1 && err === 1'b1 && done !== 1'b1) chk("err_without_done", 1, 0);
         if (clr === 1'b1 && done === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = q.pop_front();
               chk("latency", 64'(cyc - e.scyc), 64'(e.lat));
               chk("err", {63'd0, err}, {63'd0, e.eerr});
               chk("hi", {32'd0, hi}, {32'd0, e.ehi});
               chk("lo", {32'd0, lo}, {32'd0, e.elo});
               mon_sel = e.dest;
               mon_own = 1'b1;
               #1;
               chk("dest_reg", {32'd0, dbg_data}, {32'd0, e.dval});
               mon_own = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      if (busy) chk("wait_idle_timeout", 1, 0);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk("queue_drained", 64'(q.size()), 0);
      tick();
   endtask

   task automatic load(input int r, input logic [31:0] v);
      wait_idle();
      ra = 4'(r);
      load_data = v;
      load_en = 1'b1;
      tick();
      load_en = 1'b0;
      if (r != 0) mregs[r] = v;
   endtask

   // issue one op; expectation comes from plain arithmetic on the model registers
   task automatic do_op(input int o, input int d, input int s1, input int s2,
                        input bit push, input bit same_load, input bit busy_load);
      exp_t        e;
      logic [31:0] yv, cv;
      logic [63:0] p;
      wait_idle();
      yv = mregs[s1];
      cv = mregs[s2];
      e.ehi = mhi;
      e.elo = mlo;
      e.eerr = 1'b0;
      e.lat = 4;
      case (o)
         0: e.dval = yv + cv;
         1: e.dval = yv - cv;
         2: e.dval = yv & cv;
         3: e.dval = yv | cv;
         4: e.dval = yv << cv[4:0];
         5: e.dval = yv >> cv[4:0];
         6: begin
            p = 64'(yv) * 64'(cv);
            e.dval = p[31:0];
            e.ehi = p[63:32];
            e.lat = 35;
         end
         default: begin
            if (cv == 0) begin
               e.dval = 32'hFFFF_FFFF;
               e.ehi = yv;
               e.eerr = 1'b1;
            end else begin
               e.dval = yv / cv;
               e.ehi = yv % cv;
               e.lat = 35;
            end
         end
      endcase
      if (o >= 6) e.elo = e.dval;
      if (d == 0) e.dval = 0;
      e.dest = 4'(d);
      e.scyc = cyc;
      op = 3'(o);
      ra = 4'(d);
      rb = 4'(s1);
      rc = 4'(s2);
      start = 1'b1;
      if (same_load) begin
         load_en = 1'b1;
         load_data = 32'hDEAD_0099;
      end
      if (push) begin
         q.push_back(e);
         if (d != 0) mregs[d] = e.dval;
         mhi = e.ehi;
         mlo = e.elo;
      end
      tick();
      start = 1'b0;
      load_en = 1'b0;
      op = 3'($urandom_range(0, 7));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 4'($urandom_range(0, 15));
      if (busy_load) begin
         ra = 4'd11;
         load_data = $urandom;
         load_en = 1'b1;
         tick();
         tick();
         load_en = 1'b0;
      end
   endtask

   task automatic sweep(input string nm);
      for (int i = 0; i < 16; i++) begin
         stim_sel = 4'(i);
         #1;
         chk(nm, {32'd0, dbg_data}, {32'd0, mregs[i]});
      end
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 4))
         0:       return 32'd0;
         1, 2:    return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      clr = 1'b0;
      start = 1'b0;
      load_en = 1'b0;
      op = '0;
      ra = '0;
      rb = '0;
      rc = '0;
      load_data = '0;
      stim_sel = '0;
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      mhi = '0;
      mlo = '0;
      repeat (3) tick();
      chk("rst_busy", {63'd0, busy}, 0);
      chk("rst_done", {63'd0, done}, 0);
      chk("rst_err", {63'd0, err}, 0);
      chk("rst_hi", {32'd0, hi}, 0);
      chk("rst_lo", {32'd0, lo}, 0);
      sweep("rst_reg");
      clr = 1'b1;
      tick();

      // directed scenarios
      load(1, 7); load(2, 5);
      do_op(0, 3, 1, 2, 1, 0, 0);
      load(1, 32'hFFFF_FFFF); load(2, 1);
      do_op(0, 4, 1, 2, 1, 0, 0);
      do_op(1, 5, 2, 1, 1, 0, 0);
      load(1, 32'h0001_0000); load(2, 32'h0001_0000);
      do_op(6, 6, 1, 2, 1, 0, 0);
      load(1, 100); load(2, 7);
      do_op(7, 8, 1, 2, 1, 0, 0);
      load(2, 0);
      do_op(7, 9, 1, 2, 1, 0, 0);
      do_op(0, 0, 1, 1, 1, 0, 0);
      load(0, 32'h1234_5678);
      load(1, 3); load(2, 4);
      do_op(0, 1, 1, 2, 1, 1, 0);
      do_op(6, 10, 1, 2, 1, 0, 1);
      do_op(1, 2, 2, 1, 1, 0, 0);
      do_op(4, 12, 1, 2, 1, 0, 0);
      do_op(5, 13, 6, 2, 1, 0, 0);
      drain();
      sweep("directed_reg");

      // abort a MUL mid-flight
      load(1, 32'h0000_1234); load(2, 32'h0000_0057);
      do_op(6, 6, 1, 2, 0, 0, 0);
      repeat (8) tick();
      #2;
      clr = 1'b0;
      #1;
      chk("abort_busy", {63'd0, busy}, 0);
      chk("abort_done", {63'd0, done}, 0);
      tick();
      clr = 1'b1;
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      mhi = '0;
      mlo = '0;
      repeat (40) tick();
      chk("abort_hi", {32'd0, hi}, 0);
      chk("abort_lo", {32'd0, lo}, 0);
      sweep("abort_reg");

      // randomized traffic
      for (int k = 0; k < 60; k++) begin
         int nl = $urandom_range(0, 2);
         for (int j = 0; j < nl; j++) load($urandom_range(0, 15), rnd_val());
         do_op($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), 1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end
      wait_idle();
      drain();
      sweep("final_reg");
      chk("final_hi", {32'd0, hi}, {32'd0, mhi});
      chk("final_lo", {32'd0, lo}, {32'd0, mlo});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bus_datapath_seq.md
BUS_DATAPATH_SEQ -- requirements
Module: bus_datapath_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of registers, bus and ALU; even, 8..64.
REQ-002 SHALL have parameter NREGS, default 16: general register count; power of two, 4..32; AW = log2(NREGS).
REQ-003 SHALL have parameter R0_ZERO, default 1: when 1, r0 reads as zero and ignores writes.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 clr  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request one operation; sampled only in IDLE.
REQ-007 op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 MUL, 7 DIV.
REQ-008 ra, rb, rc  input  AW each  destination, first source, second source.
REQ-009 load_en, load_data  input  1 / WIDTH  external write of load_data into register ra.
REQ-010 dbg_sel / dbg_data  input AW / output WIDTH  combinational read of any general register.
REQ-011 busy  output  1  high in every non-IDLE state.
REQ-012 done  output  1  registered one-cycle pulse on operation completion.
REQ-013 err  output  1  registered, pulses with done on DIV by zero; otherwise low.
REQ-014 hi, lo  output  WIDTH each  contents of HI and LO registers.

Function
REQ-015 FSM states SHALL be IDLE, LOADY, EXEC, WRITE; IDLE->LOADY on start, LOADY->EXEC, EXEC->WRITE when the ALU result is ready, WRITE->IDLE.
REQ-016 ra/rb/rc/op SHALL be captured at the start edge; later input changes SHALL NOT affect the operation in flight.
REQ-017 LOADY SHALL load Y with register rb; EXEC SHALL compute Y op register rc into Zhi/Zlo.
REQ-018 ADD/SUB SHALL be modulo 2^WIDTH with no carry output; AND/OR bitwise; Zhi SHALL be 0 for these ops.
REQ-019 SHL/SHR SHALL be logical shifts of Y by rc[log2(WIDTH)-1:0]; vacated bits SHALL be zero.
REQ-020 MUL SHALL be unsigned iterative shift-add, exactly WIDTH EXEC cycles, with the 2*WIDTH product in {Zhi,Zlo}.
REQ-021 DIV SHALL be unsigned restoring, exactly WIDTH EXEC cycles, with quotient in Zlo and remainder in Zhi.
REQ-022 DIV with rc value 0 SHALL spend 1 EXEC cycle and give quotient all-ones, remainder = Y, err = 1.
REQ-023 Non-iterative ops SHALL spend 1 EXEC cycle.
REQ-024 WRITE SHALL write Zlo to ra; MUL/DIV SHALL also write Zhi to HI and Zlo to LO; other ops SHALL leave HI/LO unchanged.
REQ-025 done SHALL be high during the first IDLE cycle after WRITE, giving start-edge-to-done latency 4 cycles for simple ops and WIDTH+3 for MUL/DIV (non-zero divisor).
REQ-026 ra = rb or ra = rc SHALL be legal; sources SHALL be read before the write.
REQ-027 With R0_ZERO=1, r0 as a source SHALL read 0 and writes to r0 (WRITE or load) SHALL be discarded.
REQ-028 start while busy SHALL be ignored; no queueing.
REQ-029 load_en SHALL take effect only in IDLE; load_en while busy SHALL be dropped.
REQ-030 start and load_en in the same IDLE cycle: start wins and the load is dropped.
REQ-031 start in the cycle done is high SHALL be accepted, allowing back-to-back operations.

Reset
REQ-032 clr low SHALL asynchronously force state IDLE; clear all general registers, Y, Zhi, Zlo, HI, LO and the iteration counter; and drive busy = done = err = 0.
REQ-033 clr asserted mid-operation SHALL abort the operation with no register write and no done pulse.

Structure
REQ-034 Op codes, the state enum, and the defaults for WIDTH/NREGS SHALL live in shared package datapath_pkg.
REQ-035 The iterative MUL/DIV engine SHALL be sub-module seq_muldiv (go/ready handshake, WIDTH parameter); the register file, bus and FSM SHALL remain in bus_datapath_seq.

Verification (WIDTH=32, NREGS=16)
REQ-036 Load r1=7, r2=5; ADD ra=3 -> done 4 cycles after start, r3=12, hi/lo unchanged.
REQ-037 r1=0xFFFFFFFF, r2=1; ADD to r4 -> r4=0; SUB r2-r1 into r5 -> r5=2.
REQ-038 r1=0x10000, r2=0x10000; MUL to r6 -> done at cycle 35, hi=1, lo=0, r6=0.
REQ-039 r1=100, r2=7; DIV -> lo=r_dest=14, hi=2, err=0; then r2=0 DIV -> lo=0xFFFFFFFF, hi=100, err=1, latency 4.
REQ-040 MUL started, clr pulsed low at cycle 10 -> busy=0 immediately, all registers 0, no done; start and load_en same cycle -> load dropped; ADD to r0 -> r0 stays 0.
